// File: rtl/calc_n_pkg.sv
// Shared types for the NUM_CH-channel calculator: command/response encodings,
// capture FSM states and the default-width request queue entry.
package calc_n_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2,
    RSVD = 2'd3
  } resp_e;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_st_e;

  localparam int DEF_CMD_W  = 4;
  localparam int DEF_DATA_W = 32;

  // Queue entry layout at the default widths; the channel queue builds the
  // same {cmd, op1, op2} layout from its own parameters.
  typedef struct packed {
    logic [DEF_CMD_W-1:0]  cmd;
    logic [DEF_DATA_W-1:0] op1;
    logic [DEF_DATA_W-1:0] op2;
  } entry_t;

endpackage

// File: rtl/calc_n_ch_fifo.sv
// One request channel: two-cycle capture FSM, request queue, busy and
// sticky drop flag. The arbiter pops the head through pop_in.
module calc_n_ch_fifo
  import calc_n_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop_in,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  drop_out,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic [DATA_WIDTH-1:0] op1_out,
  output logic [DATA_WIDTH-1:0] op2_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [CMD_WIDTH-1:0]  cmd;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
  } ent_t;

  cap_st_e               st_q, st_d;
  logic [CMD_WIDTH-1:0]  cmd_h_q, cmd_h_d;
  logic [DATA_WIDTH-1:0] op1_h_q, op1_h_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  push, pop, busy;
  ent_t                  mem_q [FIFO_DEPTH];
  ent_t                  head;

  // The OP2 cycle holds a reserved slot, so a push never finds the queue full.
  assign busy = (cnt_q + CW'(st_q == CAP_OP2)) == CW'(FIFO_DEPTH);
  assign pop  = pop_in && (cnt_q != '0);

  always_comb begin
    st_d    = st_q;
    cmd_h_d = cmd_h_q;
    op1_h_d = op1_h_q;
    drop_d  = drop_q;
    push    = 1'b0;
    case (st_q)
      CAP_IDLE: begin
        if (cmd_in != '0) begin
          if (busy) begin
            drop_d = 1'b1;
          end else begin
            cmd_h_d = cmd_in;
            op1_h_d = data_in;
            st_d    = CAP_OP2;
          end
        end
      end
      CAP_OP2: begin
        push = 1'b1;
        st_d = CAP_IDLE;
      end
      default: st_d = CAP_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= CAP_IDLE;
      cmd_h_q  <= '0;
      op1_h_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cmd_h_q  <= cmd_h_d;
      op1_h_q  <= op1_h_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{cmd: cmd_h_q, op1: op1_h_q, op2: data_in};
  end

  assign head      = mem_q[rd_ptr_q];
  assign valid_out = (cnt_q != '0);
  assign busy_out  = busy;
  assign drop_out  = drop_q;
  assign cmd_out   = head.cmd;
  assign op1_out   = head.op1;
  assign op2_out   = head.op2;

endmodule

// File: rtl/calc_n_arb.sv
// NUM_CH request channels sharing one registered ALU through a round-robin
// arbiter. Define CALC_N_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module calc_n_arb
  import calc_n_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 4,
  parameter int RESP_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*CMD_WIDTH-1:0]  req_cmd_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_CH-1:0]            req_busy_out,
  output logic [NUM_CH-1:0]            req_drop_out,
  output logic [NUM_CH*RESP_WIDTH-1:0] out_resp,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SH_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [NUM_CH-1:0]     ch_vld, ch_pop;
  logic [CMD_WIDTH-1:0]  ch_cmd [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_op1 [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_op2 [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    calc_n_ch_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .CMD_WIDTH (CMD_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cmd_in   (req_cmd_in[g*CMD_WIDTH +: CMD_WIDTH]),
      .data_in  (req_data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop_in   (ch_pop[g]),
      .valid_out(ch_vld[g]),
      .busy_out (req_busy_out[g]),
      .drop_out (req_drop_out[g]),
      .cmd_out  (ch_cmd[g]),
      .op1_out  (ch_op1[g]),
      .op2_out  (ch_op2[g])
    );
  end

  logic [PTR_W-1:0] start, cand, grant_idx;
  logic             grant_vld;

`ifdef CALC_N_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign start = ptr_q;
`endif

  // Scan channels starting at 'start', wrapping once around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(start) + i >= NUM_CH) cand = PTR_W'(int'(start) + i - NUM_CH);
      else                           cand = PTR_W'(int'(start) + i);
      if (!grant_vld && ch_vld[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    ch_pop = '0;
    for (int c = 0; c < NUM_CH; c++) ch_pop[c] = grant_vld && (grant_idx == PTR_W'(c));
  end

  logic [CMD_WIDTH-1:0]  alu_cmd;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_data;
  logic [DATA_WIDTH:0]   alu_sum;
  logic [RESP_WIDTH-1:0] alu_resp;

  assign alu_cmd = ch_cmd[grant_idx];
  assign alu_a   = ch_op1[grant_idx];
  assign alu_b   = ch_op2[grant_idx];
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  // Errors always return zero data.
  always_comb begin
    alu_resp = RESP_WIDTH'(OK);
    alu_data = '0;
    case (alu_cmd)
      CMD_WIDTH'(ADD): begin
        if (alu_sum[DATA_WIDTH]) alu_resp = RESP_WIDTH'(ERR);
        else                     alu_data = alu_sum[DATA_WIDTH-1:0];
      end
      CMD_WIDTH'(SUB): begin
        if (alu_b > alu_a) alu_resp = RESP_WIDTH'(ERR);
        else               alu_data = alu_a - alu_b;
      end
      CMD_WIDTH'(SHL): alu_data = alu_a << alu_b[SH_W-1:0];
      CMD_WIDTH'(SHR): alu_data = alu_a >> alu_b[SH_W-1:0];
      default:         alu_resp = RESP_WIDTH'(ERR);
    endcase
  end

  logic [NUM_CH*RESP_WIDTH-1:0] resp_q, resp_d;
  logic [NUM_CH*DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    resp_d = '0;
    data_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_pop[c]) begin
        resp_d[c*RESP_WIDTH +: RESP_WIDTH] = alu_resp;
        data_d[c*DATA_WIDTH +: DATA_WIDTH] = alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
      data_q <= '0;
    end else begin
      resp_q <= resp_d;
      data_q <= data_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;

endmodule
